// File: rtl/dm_responder.sv
// Data-memory responder: serves one read or byte-enabled write at a time
// after a fixed latency, flagging misaligned/out-of-range accesses.
module dm_responder #(
  parameter int          WORDS     = 3072,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  count;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [3:0]  lat_byteen;
  logic [31:0] lat_wdata;
  logic [31:0] mem [WORDS];

  logic             use_req;
  logic             commit;
  logic             c_we;
  logic [31:0]      c_addr;
  logic [3:0]       c_byteen;
  logic [31:0]      c_wdata;
  logic [32:0]      c_diff;
  logic             c_err;
  logic [IDX_W-1:0] c_idx;
  logic             unused_bits;

  assign req_ready = (state == IDLE);

  // With LATENCY==1 the commit edge is the accepting edge, so the live
  // request fields feed the commit path instead of the latched copy.
  assign use_req  = (state == IDLE);
  assign c_we     = use_req ? req_we     : lat_we;
  assign c_addr   = use_req ? req_addr   : lat_addr;
  assign c_byteen = use_req ? req_byteen : lat_byteen;
  assign c_wdata  = use_req ? req_wdata  : lat_wdata;

  assign commit = (req_ready && req_valid && (LATENCY == 1)) ||
                  ((state == WAIT) && (count == 4'd1));

  // Borrow out of the 33-bit subtraction marks an address below the base.
  assign c_diff      = {1'b0, c_addr} - {1'b0, BASE_ADDR};
  assign c_err       = (c_addr[1:0] != 2'b00) || c_diff[32] || (c_diff[31:0] >= SPAN);
  assign c_idx       = c_diff[IDX_W+1:2];
  assign unused_bits = ^{c_diff[31:IDX_W+2], c_diff[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (commit && c_we && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (c_byteen[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_byteen <= '0;
      lat_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_addr   <= req_addr;
            lat_byteen <= req_byteen;
            lat_wdata  <= req_wdata;
            count      <= 4'(LATENCY - 1);
            state      <= WAIT;
          end
        end
        WAIT: count <= count - 4'd1;
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        resp_err   <= c_err;
        resp_rdata <= (c_err || c_we) ? 32'h0 : mem[c_idx];
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Randomized scoreboard bench for dm_responder; one instance at LATENCY=2
// and one at LATENCY=1 share the request bus but have separate req_valid.
module tb_dm_responder;

  localparam int          WORDS = 3072;
  localparam longint      BASE  = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid [2];
  logic        reqReady [2];
  logic        reqWe;
  logic [31:0] reqAddr;
  logic [3:0]  reqByteen;
  logic [31:0] reqWdata;
  logic        respValid [2];
  logic        respReady;
  logic [31:0] respRdata [2];
  logic        respErr [2];

  always #5 clk = ~clk;

  dm_responder #(.WORDS(WORDS), .BASE_ADDR(32'h0), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .req_we(reqWe), .req_addr(reqAddr), .req_byteen(reqByteen), .req_wdata(reqWdata),
    .resp_valid(respValid[0]), .resp_ready(respReady), .resp_rdata(respRdata[0]),
    .resp_err(respErr[0])
  );

  dm_responder #(.WORDS(WORDS), .BASE_ADDR(32'h0), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .req_we(reqWe), .req_addr(reqAddr), .req_byteen(reqByteen), .req_wdata(reqWdata),
    .resp_valid(respValid[1]), .resp_ready(respReady), .resp_rdata(respRdata[1]),
    .resp_err(respErr[1])
  );

  typedef struct {
    int          d;
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        expQ [$];
  logic [31:0] mdl [2][WORDS];
  int          negCnt = 0;
  int          nVec = 0;
  int          nErr = 0;
  bit          seen [2];
  bit          readyNext [2];
  int          stall = 0;
  bit          randBp = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nVec++;
    if (act !== expv) begin
      nErr++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference behaviour: a flat word array updated by byte lanes
  function automatic void model(input int d, input bit we, input logic [31:0] a,
                                input logic [3:0] be, input logic [31:0] wd,
                                output logic [31:0] rd, output logic e);
    longint la = longint'(a);
    int     idx;
    e  = (a % 4 != 0) || (la < BASE) || (la >= BASE + 4 * WORDS);
    rd = 32'h0;
    if (!e) begin
      idx = int'((la - BASE) / 4);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rd = mdl[d][idx];
      end
    end
  endfunction

  task automatic clearModel();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < WORDS; i++) mdl[d][i] = 32'h0;
  endtask

  task automatic waitIdle(input int d);
    int n = 0;
    while ((expQ.size() != 0 || !reqReady[d]) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      nVec++; nErr++;
      $display("[TB] FAIL timeout: dut%0d not idle after %0d cycles", d, n);
    end
  endtask

  task automatic applyStimulus(input int d, input bit we, input logic [31:0] a,
                               input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] rd;
    logic        e;
    int          lat = (d == 0) ? 2 : 1;
    waitIdle(d);
    reqValid[d] = 1'b1;
    reqWe       = we;
    reqAddr     = a;
    reqByteen   = be;
    reqWdata    = wd;
    @(posedge clk);
    model(d, we, a, be, wd, rd, e);
    expQ.push_back('{d: d, due: negCnt + lat, rdata: rd, err: e});
    #1;
    reqValid[d] = 1'b0;
    reqWe       = 1'($urandom);
    reqAddr     = $urandom;
    reqByteen   = 4'($urandom);
    reqWdata    = $urandom;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    clearModel();
  endtask

  always @(posedge clk) begin
    #1;
    if (stall > 0) begin
      respReady = 1'b0;
      stall--;
    end else begin
      respReady = randBp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: checks every visible response cycle against the queue head
  always @(negedge clk) begin
    negCnt++;
    for (int d = 0; d < 2; d++) begin
      if (readyNext[d]) begin
        checkOutput("ready_after_handshake", 32'(reqReady[d]), 32'd1);
        readyNext[d] = 1'b0;
      end
      if (expQ.size() > 0 && expQ[0].d == d) begin
        checkOutput("ready_low_busy", 32'(reqReady[d]), 32'd0);
        if (respValid[d]) begin
          if (!seen[d]) begin
            checkOutput("latency", negCnt, expQ[0].due);
            seen[d] = 1'b1;
          end
          checkOutput("rdata", respRdata[d], expQ[0].rdata);
          checkOutput("err", 32'(respErr[d]), 32'(expQ[0].err));
          if (respReady) begin
            void'(expQ.pop_front());
            seen[d]      = 1'b0;
            readyNext[d] = 1'b1;
          end
        end
      end else begin
        checkOutput("no_stray_resp", 32'(respValid[d]), 32'd0);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    reqValid[0] = 1'b0;
    reqValid[1] = 1'b0;
    reqWe       = 1'b0;
    reqAddr     = '0;
    reqByteen   = '0;
    reqWdata    = '0;
    respReady   = 1'b1;
    applyReset();
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_req_ready", 32'(reqReady[d]), 32'd1);
      checkOutput("reset_resp_valid", 32'(respValid[d]), 32'd0);
      checkOutput("reset_rdata", respRdata[d], 32'd0);
      checkOutput("reset_err", 32'(respErr[d]), 32'd0);
    end

    applyStimulus(0, 0, 32'h0000_0010, 4'h0, 32'h0);
    applyStimulus(0, 1, 32'h0000_0100, 4'b1111, 32'h1234_5678);
    applyStimulus(0, 1, 32'h0000_0100, 4'b0010, 32'hAABB_CCDD);
    applyStimulus(0, 0, 32'h0000_0100, 4'h0, 32'h0);
    applyStimulus(0, 0, 32'h0000_0102, 4'h0, 32'h0);
    applyStimulus(0, 0, 32'h0000_3000, 4'h0, 32'h0);
    applyStimulus(0, 0, 32'h0000_0100, 4'h0, 32'h0);
    applyStimulus(0, 1, 32'h0000_0100, 4'b0000, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 32'h0000_0100, 4'h0, 32'h0);
    applyStimulus(0, 1, 32'h0000_2FFC, 4'b1111, 32'hCAFE_F00D);
    applyStimulus(0, 0, 32'h0000_2FFC, 4'h0, 32'h0);

    waitIdle(0);
    stall = 8;
    applyStimulus(0, 0, 32'h0000_0100, 4'h0, 32'h0);

    // Reset lands on the edge that would have committed this write
    waitIdle(0);
    reqValid[0] = 1'b1;
    reqWe       = 1'b1;
    reqAddr     = 32'h0000_0200;
    reqByteen   = 4'b1111;
    reqWdata    = 32'h5555_AAAA;
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    applyReset();
    applyStimulus(0, 0, 32'h0000_0200, 4'h0, 32'h0);
    applyStimulus(0, 0, 32'h0000_0100, 4'h0, 32'h0);

    applyStimulus(1, 1, 32'h0000_0004, 4'b1111, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 32'h0000_0004, 4'h0, 32'h0);

    randBp = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 150; k++) begin
        logic [31:0] a;
        int          r = $urandom_range(0, 9);
        if (r < 7)       a = 32'(4 * $urandom_range(0, 15));
        else if (r == 7) a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
        else if (r == 8) a = 32'(32'h3000 + 4 * $urandom_range(0, 3));
        else             a = ($urandom_range(0, 1) == 1) ? 32'h0000_2FFC : 32'hFFFF_FFFC;
        applyStimulus(d, 1'($urandom), a, 4'($urandom), $urandom);
      end
    end
    randBp = 1'b0;
    waitIdle(0);
    waitIdle(1);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
